// File: rtl/pipelined_decoder_if.sv
// Fetch/execute handshake bundle for pipelined_decoder. The decoder uses the slave modport and the
// fetch/execute environment uses the master modport.
interface pipelined_decoder_if #(
  parameter int unsigned INSTR_W = 64,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned IMM_W   = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [3:0]         flags;
  logic               flags_wb;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         op;
  logic [RA_W-1:0]    addr_a;
  logic [RA_W-1:0]    addr_b;
  logic [RA_W-1:0]    write_addr;
  logic [IMM_W-1:0]   immediate;
  logic               regwrite;
  logic               use_imm;
  logic               memwrite;
  logic               memtoreg;
  logic               branch;
  logic               setflags;
  logic               flag_stall;

  modport master (
    output in_valid, instr, flags, flags_wb, out_ready,
    input  in_ready, out_valid, op, addr_a, addr_b, write_addr, immediate,
    input  regwrite, use_imm, memwrite, memtoreg, branch, setflags, flag_stall
  );

  modport slave (
    input  in_valid, instr, flags, flags_wb, out_ready,
    output in_ready, out_valid, op, addr_a, addr_b, write_addr, immediate,
    output regwrite, use_imm, memwrite, memtoreg, branch, setflags, flag_stall
  );
endinterface

// File: rtl/pipelined_decoder.sv
// Single-stage instruction decoder with flag-hazard interlock on conditional branches.
// Define DECODER_SKID_EN to add a one-entry skid buffer so in_ready no longer depends on out_ready.
module pipelined_decoder #(
  parameter int unsigned INSTR_W      = 64,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned IMM_W        = 32,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input logic               clk,
  input logic               rst,
  pipelined_decoder_if.slave bus
);
  localparam int unsigned PW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [7:0] OpAdd  = 8'h01;
  localparam logic [7:0] OpAddi = 8'h02;
  localparam logic [7:0] OpSub  = 8'h03;
  localparam logic [7:0] OpSubi = 8'h04;
  localparam logic [7:0] OpCmp  = 8'h05;
  localparam logic [7:0] OpCmpi = 8'h06;
  localparam logic [7:0] OpLdr  = 8'h07;
  localparam logic [7:0] OpStr  = 8'h08;
  localparam logic [7:0] OpB    = 8'h10;
  localparam logic [7:0] OpBr   = 8'h11;
  // Conditional branches: immediate forms 0x20..0x25, register forms 0x28..0x2D.
  // Low three bits select EQ, NE, GT, GE, LT, LE in both ranges.
  localparam logic [7:0] OpBeq  = 8'h20;
  localparam logic [7:0] OpBle  = 8'h25;
  localparam logic [7:0] OpBreq = 8'h28;
  localparam logic [7:0] OpBrle = 8'h2D;

  typedef struct packed {
    logic [7:0]       op;
    logic [RA_W-1:0]  write_addr;
    logic [RA_W-1:0]  addr_a;
    logic [RA_W-1:0]  addr_b;
    logic [IMM_W-1:0] immediate;
    logic             regwrite;
    logic             use_imm;
    logic             memwrite;
    logic             memtoreg;
    logic             branch;
    logic             setflags;
  } bundle_t;

  bundle_t        dec;
  bundle_t        out_d, out_q;
  logic           out_valid_d, out_valid_q;
  logic [PW-1:0]  pend_d, pend_q;
  logic           is_cond, cond_true;
  logic           flag_n, flag_z;
  logic           pend_nz, pend_full;
  logic           cond_hold, sf_hold, space_ok;
  logic           in_ready_w, accept, pop;
  logic           unused_bits;

`ifdef DECODER_SKID_EN
  bundle_t        skid_d, skid_q;
  logic           skid_valid_d, skid_valid_q;
`endif

  assign flag_n      = bus.flags[0];
  assign flag_z      = bus.flags[1];
  assign unused_bits = ^{bus.flags[3:2], bus.instr};

  always_comb begin
    dec            = '0;
    dec.op         = bus.instr[7:0];
    dec.write_addr = bus.instr[8 +: RA_W];
    dec.addr_a     = bus.instr[8 + RA_W +: RA_W];
    dec.addr_b     = bus.instr[8 + 2 * RA_W +: RA_W];
    dec.immediate  = bus.instr[INSTR_W - IMM_W +: IMM_W];
    is_cond        = (dec.op >= OpBeq && dec.op <= OpBle) || (dec.op >= OpBreq && dec.op <= OpBrle);
    cond_true      = 1'b0;
    case (dec.op[2:0])
      3'd0:    cond_true = flag_z;
      3'd1:    cond_true = ~flag_z;
      3'd2:    cond_true = ~flag_n & ~flag_z;
      3'd3:    cond_true = ~flag_n | flag_z;
      3'd4:    cond_true = flag_n & ~flag_z;
      default: cond_true = flag_n | flag_z;
    endcase
    case (dec.op)
      OpAdd, OpSub: begin
        dec.regwrite = 1'b1;
        dec.setflags = 1'b1;
      end
      OpAddi, OpSubi: begin
        dec.regwrite = 1'b1;
        dec.use_imm  = 1'b1;
        dec.setflags = 1'b1;
      end
      OpCmp:  dec.setflags = 1'b1;
      OpCmpi: begin
        dec.setflags = 1'b1;
        dec.use_imm  = 1'b1;
      end
      OpLdr: begin
        dec.regwrite = 1'b1;
        dec.memtoreg = 1'b1;
      end
      OpStr: dec.memwrite = 1'b1;
      OpB: begin
        dec.branch  = 1'b1;
        dec.use_imm = 1'b1;
      end
      OpBr:  dec.branch = 1'b1;
      default: begin
        if (is_cond) begin
          dec.branch  = cond_true;
          dec.use_imm = (dec.op <= OpBle);
        end
      end
    endcase
  end

  assign pend_nz   = (pend_q != '0);
  assign pend_full = (pend_q == PW'(MAX_INFLIGHT));
  // A branch must not resolve on flags that an older, unretired instruction will still change.
  assign cond_hold = is_cond & (pend_nz | (out_valid_q & out_q.setflags));
  assign sf_hold   = dec.setflags & pend_full & ~bus.flags_wb;

`ifdef DECODER_SKID_EN
  assign space_ok = ~skid_valid_q;
`else
  assign space_ok = ~out_valid_q | bus.out_ready;
`endif

  assign in_ready_w     = ~rst & space_ok & ~cond_hold & ~sf_hold;
  assign accept         = bus.in_valid & in_ready_w;
  assign pop            = out_valid_q & bus.out_ready;
  assign bus.in_ready   = in_ready_w;
  assign bus.flag_stall = ~rst & bus.in_valid & cond_hold;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pend_d      = pend_q;
`ifdef DECODER_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (pop) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (~out_valid_q | pop) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
`else
    if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
`endif
    if ((accept & dec.setflags) && !(bus.flags_wb & pend_nz)) begin
      pend_d = pend_q + PW'(1);
    end else if (!(accept & dec.setflags) && (bus.flags_wb & pend_nz)) begin
      pend_d = pend_q - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      pend_q      <= '0;
`ifdef DECODER_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
`endif
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      pend_q      <= pend_d;
`ifdef DECODER_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
`endif
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.op         = out_q.op;
  assign bus.write_addr = out_q.write_addr;
  assign bus.addr_a     = out_q.addr_a;
  assign bus.addr_b     = out_q.addr_b;
  assign bus.immediate  = out_q.immediate;
  assign bus.regwrite   = out_q.regwrite;
  assign bus.use_imm    = out_q.use_imm;
  assign bus.memwrite   = out_q.memwrite;
  assign bus.memtoreg   = out_q.memtoreg;
  assign bus.branch     = out_q.branch;
  assign bus.setflags   = out_q.setflags;
endmodule

// File: tb/tb_pipelined_decoder.sv
// Scoreboard bench for pipelined_decoder: directed hazard/back-pressure/reset scenarios followed by
// randomized traffic, all checked against a behavioural model of the decode and interlock rules.
module tb_pipelined_decoder;
  localparam int unsigned INSTR_W      = 64;
  localparam int unsigned RA_W         = 5;
  localparam int unsigned IMM_W        = 32;
  localparam int unsigned MAX_INFLIGHT = 3;
  localparam int unsigned BW           = 8 + 3 * RA_W + IMM_W + 6;

  localparam logic [7:0] OpAdd = 8'h01, OpAddi = 8'h02, OpSub = 8'h03, OpSubi = 8'h04;
  localparam logic [7:0] OpCmp = 8'h05, OpCmpi = 8'h06, OpLdr = 8'h07, OpStr = 8'h08;
  localparam logic [7:0] OpB = 8'h10, OpBr = 8'h11;
  localparam logic [7:0] OpBeq = 8'h20, OpBne = 8'h21, OpBgt = 8'h22, OpBge = 8'h23;
  localparam logic [7:0] OpBlt = 8'h24, OpBle = 8'h25;
  localparam logic [7:0] OpBreq = 8'h28, OpBrne = 8'h29, OpBrgt = 8'h2A, OpBrge = 8'h2B;
  localparam logic [7:0] OpBrlt = 8'h2C, OpBrle = 8'h2D;

  logic [7:0] op_tab [22] = '{OpAdd, OpAddi, OpSub, OpSubi, OpCmp, OpCmpi, OpLdr, OpStr, OpB, OpBr,
                              OpBeq, OpBne, OpBgt, OpBge, OpBlt, OpBle,
                              OpBreq, OpBrne, OpBrgt, OpBrge, OpBrlt, OpBrle};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_decoder_if #(.INSTR_W(INSTR_W), .RA_W(RA_W), .IMM_W(IMM_W)) bus ();

  pipelined_decoder #(
    .INSTR_W(INSTR_W), .RA_W(RA_W), .IMM_W(IMM_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [BW-1:0] dut_b;
  assign dut_b = {bus.op, bus.write_addr, bus.addr_a, bus.addr_b, bus.immediate,
                  bus.regwrite, bus.use_imm, bus.memwrite, bus.memtoreg, bus.branch, bus.setflags};

  logic [BW-1:0] sbq [$];
  int pend_m = 0;
  int pushed_now = 0;
  int checks = 0;
  int errors = 0;
  bit zero_next = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkb(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [4:0] wa,
                                     input logic [4:0] a, input logic [4:0] b,
                                     input logic [31:0] imm);
    return {imm, 9'h000, b, a, wa, op};
  endfunction

  function automatic bit is_cond(input logic [7:0] op);
    return op inside {OpBeq, OpBne, OpBgt, OpBge, OpBlt, OpBle,
                      OpBreq, OpBrne, OpBrgt, OpBrge, OpBrlt, OpBrle};
  endfunction

  function automatic bit is_sf(input logic [7:0] op);
    return op inside {OpAdd, OpAddi, OpSub, OpSubi, OpCmp, OpCmpi};
  endfunction

  // Expected bundle from the opcode class rules and the flags of the accepting cycle.
  function automatic logic [BW-1:0] model(input logic [63:0] ins, input logic [3:0] fl);
    logic [7:0] op;
    logic n, z, known, rw, ui, mw, mr, br, sf;
    int k;
    op    = ins[7:0];
    n     = fl[0];
    z     = fl[1];
    sf    = is_sf(op);
    known = sf || is_cond(op) || (op inside {OpLdr, OpStr, OpB, OpBr});
    ui    = (op inside {OpAddi, OpSubi, OpCmpi, OpB}) ||
            (op inside {OpBeq, OpBne, OpBgt, OpBge, OpBlt, OpBle});
    mr    = (op == OpLdr);
    mw    = (op == OpStr);
    rw    = known && !is_cond(op) && !(op inside {OpCmp, OpCmpi, OpStr, OpB, OpBr});
    br    = op inside {OpB, OpBr};
    if (is_cond(op)) begin
      k = (op >= OpBreq) ? int'(op - OpBreq) : int'(op - OpBeq);
      case (k)
        0:       br = z;
        1:       br = !z;
        2:       br = !n && !z;
        3:       br = !n || z;
        4:       br = n && !z;
        default: br = n || z;
      endcase
    end
    return {op, ins[12:8], ins[17:13], ins[22:18], ins[63:32], rw, ui, mw, mr, br, sf};
  endfunction

  // One clock of stimulus; checks in_ready/flag_stall and pushes the expected bundle on transfer.
  task automatic cycle(input bit r, input bit v, input logic [63:0] ins, input logic [3:0] fl,
                       input bit wb, input bit ordy, output bit acc);
    bit hold_c, hold_s, room, exp_rdy, sf;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.flags     = fl;
    bus.flags_wb  = wb;
    bus.out_ready = ordy;
    pushed_now    = 0;
    #1;
    sf     = is_sf(ins[7:0]);
    hold_c = is_cond(ins[7:0]) && (pend_m != 0 || (sbq.size() > 0 && sbq[0][0]));
    hold_s = sf && pend_m == int'(MAX_INFLIGHT) && !wb;
`ifdef DECODER_SKID_EN
    room = (sbq.size() < 2);
`else
    room = (sbq.size() == 0) || ordy;
`endif
    exp_rdy = !r && room && !hold_c && !hold_s;
    check1("in_ready", bus.in_ready, exp_rdy);
    check1("flag_stall", bus.flag_stall, !r && v && hold_c);
    acc = v && (bus.in_ready === 1'b1) && !r;
    if (r) begin
      sbq.delete();
      pend_m = 0;
    end else begin
      if (acc) begin
        sbq.push_back(model(ins, fl));
        pushed_now = 1;
      end
      if ((acc && sf) && !(wb && pend_m > 0)) pend_m++;
      else if (!(acc && sf) && wb && pend_m > 0) pend_m--;
    end
  endtask

  // Monitor: compares whatever the DUT presents with the scoreboard head.
  always @(negedge clk) begin
    bit exp_v;
    #2;
    if (rst) begin
      zero_next = 1'b1;
    end else begin
      exp_v = (sbq.size() - pushed_now) > 0;
      check1("out_valid", bus.out_valid, exp_v);
      if (zero_next) checkb("reset_bundle", dut_b, '0);
      zero_next = 1'b0;
      if (bus.out_valid === 1'b1 && exp_v) begin
        checkb("bundle", dut_b, sbq[0]);
        if (bus.out_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, ldr_acc;
    logic [63:0] ins;
    logic [7:0] op;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.flags     = '0;
    bus.flags_wb  = 1'b0;
    bus.out_ready = 1'b0;

    cycle(1, 0, '0, 4'h0, 0, 1, acc);
    cycle(1, 0, '0, 4'h0, 0, 1, acc);

    // ADDI wr=3 a=1 imm=0x10
    cycle(0, 1, mk(OpAddi, 5'd3, 5'd1, 5'd0, 32'h10), 4'h0, 0, 1, acc);
    check1("addi_accept", acc, 1'b1);
    cycle(0, 0, '0, 4'h0, 1, 1, acc);

    // SUB then BEQ with z=1: held until the SUB retires
    cycle(0, 1, mk(OpSub, 5'd2, 5'd1, 5'd4, 32'h0), 4'b0010, 0, 1, acc);
    check1("sub_accept", acc, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, mk(OpBeq, 5'd0, 5'd0, 5'd0, 32'h40), 4'b0010, 0, 1, acc);
      check1("beq_held", acc, 1'b0);
    end
    cycle(0, 1, mk(OpBeq, 5'd0, 5'd0, 5'd0, 32'h40), 4'b0010, 1, 1, acc);
    check1("beq_held_wb", acc, 1'b0);
    acc = 1'b0;
    for (int i = 0; i < 8 && !acc; i++)
      cycle(0, 1, mk(OpBeq, 5'd0, 5'd0, 5'd0, 32'h40), 4'b0010, 0, 1, acc);
    check1("beq_accept", acc, 1'b1);

    // BLT with n=0 z=0 and nothing pending
    cycle(0, 1, mk(OpBlt, 5'd0, 5'd0, 5'd0, 32'h80), 4'b0000, 0, 1, acc);
    check1("blt_accept", acc, 1'b1);

    // Four CMPs against MAX_INFLIGHT=3
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, mk(OpCmp, 5'd0, 5'(i), 5'(i + 1), 32'h0), 4'h0, 0, 1, acc);
      check1("cmp_accept", acc, 1'b1);
    end
    cycle(0, 1, mk(OpCmp, 5'd0, 5'd7, 5'd8, 32'h0), 4'h0, 0, 1, acc);
    check1("cmp4_held", acc, 1'b0);
    cycle(0, 1, mk(OpCmp, 5'd0, 5'd7, 5'd8, 32'h0), 4'h0, 1, 1, acc);
    check1("cmp4_accept_wb", acc, 1'b1);
    // pend stays at 3: a fifth CMP without flags_wb is refused
    cycle(0, 1, mk(OpCmp, 5'd0, 5'd9, 5'd9, 32'h0), 4'h0, 0, 1, acc);
    check1("cmp5_held", acc, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 4'h0, 1, 1, acc);

    // STR then LDR under three cycles of back-pressure
    cycle(0, 1, mk(OpStr, 5'd0, 5'd6, 5'd7, 32'h24), 4'h0, 0, 0, acc);
    check1("str_accept", acc, 1'b1);
    ldr_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, !ldr_acc, mk(OpLdr, 5'd9, 5'd6, 5'd0, 32'h28), 4'h0, 0, i >= 3, acc);
      if (acc) ldr_acc = 1'b1;
    end
    check1("ldr_accept", ldr_acc, 1'b1);

    // Reset with a bundle held and pend=2
    cycle(0, 1, mk(OpCmp, 5'd0, 5'd1, 5'd2, 32'h0), 4'h0, 0, 1, acc);
    cycle(0, 1, mk(OpCmpi, 5'd0, 5'd1, 5'd0, 32'h5), 4'h0, 0, 1, acc);
    cycle(0, 0, '0, 4'h0, 0, 0, acc);
    cycle(1, 0, '0, 4'h0, 0, 0, acc);
    cycle(0, 1, mk(OpBne, 5'd0, 5'd0, 5'd0, 32'h8), 4'b0010, 0, 1, acc);
    check1("post_reset_branch", acc, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 21)];
      ins = {$urandom, $urandom};
      ins[7:0] = op;
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, ins, 4'($urandom),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, acc);
    end

    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 4'h0, 1, 1, acc);
    check1("drain_empty", sbq.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_decoder.md
PIPELINED_DECODER -- requirements
Module: pipelined_decoder

Interface
REQ-001 The block SHALL have parameter INSTR_W, default 64, meaning instruction width in bits.
REQ-002 The block SHALL have parameter RA_W, default 5, meaning register address width.
REQ-003 The block SHALL have parameter IMM_W, default 32, meaning immediate width.
REQ-004 The block SHALL have parameter MAX_INFLIGHT, default 3, meaning maximum unretired flag-setting instructions.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and instr (input, INSTR_W): the fetch handshake.
REQ-008 The block SHALL have port flags, input, 4 bits: committed {n,z,c,v}, n at index 0.
REQ-009 The block SHALL have port flags_wb, input, 1 bit: one flag-setting instruction retired this cycle.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the execute handshake.
REQ-011 The block SHALL have registered outputs op (8 bits, header opcode), addr_a, addr_b and write_addr (RA_W each), and immediate (IMM_W).
REQ-012 The block SHALL have registered 1-bit outputs regwrite, use_imm, memwrite, memtoreg, branch and setflags.
REQ-013 The block SHALL have port flag_stall, output, 1 bit: a conditional branch is held at the input.

Function
REQ-014 Field decode SHALL be: op=instr[0:7]; write_addr next RA_W bits; addr_a next RA_W bits; addr_b next RA_W bits; immediate=instr[INSTR_W-IMM_W:INSTR_W-1].
REQ-015 Defaults SHALL be: regwrite=1; all other control bits 0.
REQ-016 use_imm SHALL be 1 for all *I opcodes, B and Bcc.
REQ-017 setflags SHALL be 1 for ADD, ADDI, SUB, SUBI, CMP and CMPI.
REQ-018 CMP and CMPI SHALL drive regwrite=0.
REQ-019 LDR SHALL drive memtoreg=1.
REQ-020 STR SHALL drive memwrite=1 and regwrite=0.
REQ-021 All branch opcodes SHALL drive regwrite=0.
REQ-022 B and BR SHALL drive branch=1.
REQ-023 Conditional branches SHALL drive branch as: EQ=z; NE=~z; GT=~n&~z; GE=~n|z; LT=n&~z; LE=n|z (register and immediate forms identical).
REQ-024 Unknown opcodes SHALL decode with all control bits 0, including regwrite.
REQ-025 A transfer SHALL occur when in_valid&in_ready; the decoded bundle SHALL appear with out_valid=1 on the next cycle (latency 1).
REQ-026 The output SHALL hold stable while out_valid&~out_ready.
REQ-027 Without skid (REQ-038), in_ready SHALL equal ~out_valid|out_ready.
REQ-028 Counter pend (0..MAX_INFLIGHT) SHALL increment on each accepted setflags instruction and decrement on flags_wb; simultaneous increment and decrement SHALL leave it unchanged.
REQ-029 A conditional branch at the input SHALL be refused (in_ready=0, flag_stall=1) while pend!=0.
REQ-030 A conditional branch SHALL also be refused while the output register holds a setflags instruction.
REQ-031 Branch conditions SHALL be evaluated on the flags value of the accepting cycle.
REQ-032 A setflags instruction SHALL be refused while pend==MAX_INFLIGHT and flags_wb=0.
REQ-033 flags_wb received with pend==0 SHALL be ignored; the counter SHALL never wrap.

Reset
REQ-034 rst SHALL force out_valid=0, pend=0, flag_stall=0 and all registered outputs to 0 on the next edge.
REQ-035 A reset asserted mid-transfer SHALL drop the in-flight bundle and the skid entry.
REQ-036 in_ready SHALL be 0 in the cycle rst is high.
REQ-037 Handshakes SHALL resume in the first cycle after rst deasserts.

Configuration
REQ-038 With DECODER_SKID_EN defined, a one-entry skid buffer SHALL be added so that in_ready is registered (1 when the skid is empty), with no bundle lost or duplicated under out_ready back-pressure and latency still 1 when unstalled.
REQ-039 Without DECODER_SKID_EN, no skid storage SHALL exist and REQ-027 SHALL apply.

Verification
REQ-040 Bench: ADDI, wr=3, a=1, imm=0x10, out_ready=1 -> next cycle out_valid=1, use_imm=1, setflags=1, regwrite=1, write_addr=3, immediate=0x10.
REQ-041 Bench: SUB then BEQ back-to-back, flags z=1 -> BEQ held with flag_stall=1 until flags_wb pulses; then accepted with branch=1.
REQ-042 Bench: BLT with flags n=0, z=0, pend=0 -> branch=0, regwrite=0, use_imm=1.
REQ-043 Bench: 4 CMPs with no flags_wb, MAX_INFLIGHT=3 -> 4th held; flags_wb in the same cycle as the 4th offer -> accepted, pend stays 3.
REQ-044 Bench: STR, then LDR with out_ready=0 for 3 cycles -> STR bundle stable (memwrite=1, regwrite=0); LDR emerges with memtoreg=1, order preserved, with and without DECODER_SKID_EN.
REQ-045 Bench: rst pulsed while out_valid=1 and pend=2 -> next cycle out_valid=0, pend=0, all outputs 0.
